// File: rtl/bus_scan_sequencer.sv
// Walks bus_selector.sel over every bus enabled in a latched mask and streams
// each sampled word out on a valid/ready interface tagged with index and last.
module bus_scan_sequencer #(
    parameter int BUS_NO = 4,
    parameter int IDX_W  = $clog2(BUS_NO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [BUS_NO-1:0] enable_mask,
    input  logic [31:0]       bus_word,
    output logic [IDX_W-1:0]  sel,
    output logic [31:0]       out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BUS_NO-1:0]   r_mask;
    logic [IDX_W-1:0]    r_sel;
    logic [31:0]         r_data;
    logic [IDX_W-1:0]    r_idx;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;
    logic                r_done;
    logic [IDX_W:0]      w_first;
    logic [IDX_W:0]      w_next;

    // Lowest set bit of mask at or above lo; MSB of the result is the found flag.
    function automatic logic [IDX_W:0] find_set(input logic [BUS_NO-1:0] mask, input int lo);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = BUS_NO - 1; i >= 0; i--) begin
            if (mask[i] && (i >= lo)) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    assign w_first = find_set(enable_mask, 0);
    assign w_next  = find_set(r_mask, int'(r_sel) + 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_first[IDX_W] ? S_SETTLE : S_DONE;
                end
            end
            S_SETTLE:  w_state_nxt = S_PRESENT;
            S_PRESENT: begin
                if (out_ready) begin
                    w_state_nxt = r_last ? S_DONE : S_SETTLE;
                end
            end
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // done trails the DONE state by one cycle, so an empty scan shows busy for
    // exactly one cycle followed by the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (r_state == S_DONE) && !abort;
            if (abort) begin
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_mask <= enable_mask;
                            if (w_first[IDX_W]) begin
                                r_sel <= w_first[IDX_W-1:0];
                            end
                        end
                    end
                    S_SETTLE: begin
                        r_data  <= bus_word;
                        r_idx   <= r_sel;
                        r_last  <= !w_next[IDX_W];
                        r_valid <= 1'b1;
                    end
                    S_PRESENT: begin
                        if (out_ready) begin
                            r_valid <= 1'b0;
                            if (!r_last) begin
                                r_sel <= w_next[IDX_W-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sel       = r_sel;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_bus_scan_sequencer.sv
// Bench for bus_scan_sequencer: table of scans checked through a word scoreboard,
// plus abort, start-while-busy and asynchronous reset sequences.
module tb_bus_scan_sequencer;

    localparam int BUS_NO = 4;
    localparam int IDX_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [BUS_NO-1:0] enable_mask = '0;
    logic [31:0]       bus_word;
    logic [IDX_W-1:0]  sel;
    logic [31:0]       out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_valid;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;

    bus_scan_sequencer #(.BUS_NO(BUS_NO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .enable_mask (enable_mask),
        .bus_word    (bus_word),
        .sel         (sel),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Mux model: bus i carries 0x11111111*(i+1).
    assign bus_word = 32'h1111_1111 * (32'(sel) + 32'd1);

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
        logic             last;
    } word_t;

    typedef struct {
        logic [BUS_NO-1:0] mask;
        int                stall;
        int                exp_words;
        int                exp_lat;
    } vec_t;

    word_t expq[$];
    word_t cur_w;
    vec_t  vecs[6];

    int nvec = 0;
    int nfail = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;
    int stall_cfg = 0;
    int stall_cnt = 0;
    logic             hold_en = 1'b0;
    logic [IDX_W-1:0] hold_idx = '0;
    logic             prev_stall = 1'b0;
    logic [31:0]      prev_data = '0;
    logic [IDX_W-1:0] prev_idx = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink: optional stall of stall_cfg cycles per word, or hold forever on hold_idx.
    always @(posedge clk) begin
        #1;
        if (hold_en && out_valid && out_idx == hold_idx) begin
            out_ready = 1'b0;
        end else if (!out_valid) begin
            stall_cnt = 0;
            out_ready = (stall_cfg == 0);
        end else if (stall_cnt < stall_cfg) begin
            out_ready = 1'b0;
            stall_cnt++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: scoreboard pops on every transfer, stall stability checks.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (out_valid) begin
            valid_cnt++;
            if (prev_stall) begin
                check("stall_data_stable", {32'd0, out_data}, {32'd0, prev_data});
                check("stall_idx_stable", 64'(out_idx), 64'(prev_idx));
            end
            if (out_ready) begin
                xfer_cnt++;
                if (expq.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_word: got idx %0d data %0h, none expected", out_idx, out_data);
                end else begin
                    cur_w = expq.pop_front();
                    check("word_idx", 64'(out_idx), 64'(cur_w.idx));
                    check("word_data", {32'd0, out_data}, {32'd0, cur_w.data});
                    check("word_last", 64'(out_last), 64'(cur_w.last));
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_idx;
    end

    task automatic push_words(input logic [BUS_NO-1:0] mask);
        int hi;
        word_t w;
        hi = -1;
        for (int i = 0; i < BUS_NO; i++) if (mask[i]) hi = i;
        for (int i = 0; i < BUS_NO; i++) begin
            if (mask[i]) begin
                w.idx  = IDX_W'(i);
                w.data = 32'h1111_1111 * 32'(i + 1);
                w.last = (i == hi);
                expq.push_back(w);
            end
        end
    endtask

    task automatic run_scan(input logic [BUS_NO-1:0] mask, input int stall,
                            input int exp_words, input int exp_lat);
        int x0, b0, d0, v0, cyc;
        stall_cfg = stall;
        @(posedge clk);
        #1;
        enable_mask = mask;
        start = 1'b1;
        push_words(mask);
        x0 = xfer_cnt; b0 = busy_cnt; d0 = done_cnt; v0 = valid_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            cyc++;
        end
        check("start_to_done", 64'(cyc), 64'(exp_lat));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("words_transferred", 64'(xfer_cnt - x0), 64'(exp_words));
        check("busy_cycles", 64'(busy_cnt - b0), 64'(exp_lat));
        check("valid_cycles", 64'(valid_cnt - v0), 64'(exp_words * (1 + stall)));
        check("scoreboard_drained", 64'(expq.size()), 64'd0);
        stall_cfg = 0;
    endtask

    task automatic wait_present(input logic [IDX_W-1:0] idx);
        bit ok;
        ok = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid && out_idx == idx) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_present", 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, 64'(sel), 64'd0);
        check({tag, "_out_data"}, {32'd0, out_data}, 64'd0);
        check({tag, "_out_idx"}, 64'(out_idx), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, d0;
        vecs[0] = '{4'b1111, 0, 4, 9};
        vecs[1] = '{4'b1010, 5, 2, 15};
        vecs[2] = '{4'b0000, 0, 0, 1};
        vecs[3] = '{4'b1000, 0, 1, 3};
        vecs[4] = '{4'b0001, 2, 1, 5};
        vecs[5] = '{4'b0110, 1, 2, 7};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_scan(vecs[v].mask, vecs[v].stall, vecs[v].exp_words, vecs[v].exp_lat);
        end

        // Abort while idx 2 is stalled in PRESENT.
        hold_en = 1'b1;
        hold_idx = 2'd2;
        @(posedge clk);
        #1;
        enable_mask = 4'b1111;
        start = 1'b1;
        push_words(4'b1111);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_present(2'd2);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid_low", 64'(out_valid), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        hold_en = 1'b0;
        expq.delete();
        repeat (5) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_sel_holds", 64'(sel), 64'd2);
        run_scan(4'b1111, 0, 4, 9);

        // Second start during an active scan is ignored.
        @(posedge clk);
        #1;
        enable_mask = 4'b1100;
        start = 1'b1;
        push_words(4'b1100);
        x0 = xfer_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        enable_mask = 4'b0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done) break;
        end
        repeat (6) @(negedge clk);
        check("busy_start_words", 64'(xfer_cnt - x0), 64'd2);
        check("busy_start_done", 64'(done_cnt - d0), 64'd1);
        check("busy_start_drained", 64'(expq.size()), 64'd0);
        check("busy_start_idle", 64'(busy), 64'd0);

        // Asynchronous reset while idx 1 is presented.
        hold_en = 1'b1;
        hold_idx = 2'd1;
        @(posedge clk);
        #1;
        enable_mask = 4'b1111;
        start = 1'b1;
        push_words(4'b1111);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_present(2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        expq.delete();
        hold_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(4'b1001, 0, 2, 5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
